// File: rtl/uart_tx_fifo_feeder.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_feeder
// Brief    : Byte FIFO plus newd/donetx handshake feeding a UART transmitter.
//            Optional watchdog in WAIT_DONE is enabled with UART_TXF_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_feeder #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int NEWD_HOLD   = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          ovf_clr,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    dintx,
  output logic          newd,
  input  logic          donetx,
  output logic          tx_timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    SEND      = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count_n;
  logic [7:0]    hold, hold_n;
  logic          sync1, sync2, sync3;
  logic          done_rise;
  logic          pop, push;

  assign done_rise = sync2 & ~sync3;
  // A pop frees a slot in the same cycle, so a write while full is still taken.
  assign push      = wr_en & (~full | pop);
  assign count_n   = count + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= donetx;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count_n;
      full  <= (count_n == (AW+1)'(DEPTH));
      empty <= (count_n == '0);
      if (wr_en && full && !pop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef UART_TXF_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  logic [WW-1:0] wdog, wdog_n;
  logic          timeout_n;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  assign tx_timeout = 1'b0;
`endif

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    hold_n  = hold;
`ifdef UART_TXF_TIMEOUT_EN
    timeout_n = 1'b0;
    wdog_n    = (state == WAIT_DONE) ? wdog + 1'b1 : '0;
`endif
    case (state)
      IDLE: begin
        if (!empty) state_n = LOAD;
      end
      LOAD: begin
        pop     = 1'b1;
        hold_n  = '0;
        state_n = SEND;
      end
      SEND: begin
        if (hold == 8'(NEWD_HOLD - 1)) begin
          hold_n  = '0;
          state_n = WAIT_DONE;
        end else begin
          hold_n = hold + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (done_rise) begin
          state_n = IDLE;
        end
`ifdef UART_TXF_TIMEOUT_EN
        else if (wdog == WW'(TIMEOUT_CYC - 1)) begin
          state_n   = IDLE;
          timeout_n = 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      hold  <= '0;
      newd  <= 1'b0;
      dintx <= 8'h00;
    end else begin
      state <= state_n;
      hold  <= hold_n;
      newd  <= (state_n == SEND);
      if (pop) dintx <= mem[rptr];
    end
  end

`ifdef UART_TXF_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog       <= '0;
      tx_timeout <= 1'b0;
    end else begin
      wdog       <= wdog_n;
      tx_timeout <= timeout_n;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo_feeder
// Brief    : Directed + randomized bench; byte order checked against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo_feeder;

  localparam int DEPTH       = 16;
  localparam int AW          = 4;
  localparam int NEWD_HOLD   = 16;
  localparam int TIMEOUT_CYC = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          ovf_clr = 1'b0;
  logic          donetx = 1'b0;
  logic          full, empty, overflow, newd, tx_timeout;
  logic [AW:0]   count;
  logic [7:0]    dintx;

  int            errors = 0;
  int            checks = 0;
  logic [7:0]    exp_q[$];
  logic [7:0]    got_q[$];
  int            newd_rises = 0;
  int            run = 0;
  bit            auto_done = 1'b0;

  uart_tx_fifo_feeder #(
    .DEPTH(DEPTH), .AW(AW), .NEWD_HOLD(NEWD_HOLD), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .dintx(dintx), .newd(newd), .donetx(donetx), .tx_timeout(tx_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transmitter-side monitor: record each presented byte and the newd pulse width.
  always @(posedge newd) begin
    #1;
    got_q.push_back(dintx);
    newd_rises++;
  end

  always @(negedge clk) begin
    if (!rst) begin
      run = 0;
    end else if (newd) begin
      run++;
    end else if (run != 0) begin
      check_eq("newd_len", run, NEWD_HOLD);
      run = 0;
    end
  end

  always begin
    @(negedge newd);
    if (auto_done && rst) begin
      repeat ($urandom_range(1, 15)) @(posedge clk);
      #3 donetx = 1'b1;
      repeat (2) @(posedge clk);
      #3 donetx = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_done();
    donetx = 1'b1;
    repeat (3) tick();
    donetx = 1'b0;
  endtask

  task automatic wait_send_done(input string tag);
    int n = 0;
    bit saw = 1'b0;
    while (!newd && n < 200) begin tick(); n++; end
    saw = newd;
    while (newd && n < 400) begin tick(); n++; end
    check_eq({tag, "_wait_done_reached"}, 32'(saw && !newd), 1);
  endtask

  task automatic compare_queues(input string tag);
    int n;
    check_eq({tag, "_bytes"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    auto_done = 1'b1;
    while (!(got_q.size() >= exp_q.size() && empty && !newd) && n < 4000) begin
      tick();
      n++;
    end
    repeat (40) tick();
    auto_done = 1'b0;
    check_eq({tag, "_count0"}, count, 0);
    check_eq({tag, "_empty"}, empty, 1);
    compare_queues(tag);
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int snap;
    int n;

    // Reset state
    repeat (2) tick();
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_newd", newd, 0);
    check_eq("rst_dintx", dintx, 8'h00);
    check_eq("rst_tx_timeout", tx_timeout, 0);
    rst = 1'b1;
    tick();

    // Single byte
    write_byte(8'hA5);
    exp_q.push_back(8'hA5);
    wait_send_done("single");
    check_eq("single_dintx", dintx, 8'hA5);
    check_eq("single_tx_timeout", tx_timeout, 0);
    repeat (20) tick();
    check_eq("single_count_in_wait", count, 0);
    check_eq("single_newd_held_low", newd, 0);
    pulse_done();
    repeat (6) tick();
    check_eq("single_empty", empty, 1);
    check_eq("single_count", count, 0);
    check_eq("single_one_request", newd_rises, 1);
    compare_queues("single");

    // Burst, overflow and simultaneous push/pop with a byte parked in WAIT_DONE
    write_byte(8'h77);
    exp_q.push_back(8'h77);
    wait_send_done("blocker");
    for (int i = 1; i <= 16; i++) begin
      write_byte(8'(i));
      exp_q.push_back(8'(i));
    end
    tick();
    check_eq("burst_full", full, 1);
    check_eq("burst_count", count, 16);
    check_eq("burst_empty", empty, 0);
    write_byte(8'hFF);
    tick();
    check_eq("ovf_set", overflow, 1);
    check_eq("ovf_count", count, 16);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tick();
    check_eq("ovf_cleared", overflow, 0);
    wr_en = 1'b1; wr_data = 8'hFF; ovf_clr = 1'b1;
    tick();
    wr_en = 1'b0; ovf_clr = 1'b0;
    tick();
    check_eq("ovf_set_wins", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tick();
    check_eq("ovf_cleared2", overflow, 0);
    // done edge -> 2 sync flops -> IDLE -> LOAD; the write lands on the LOAD pop
    donetx = 1'b1;
    repeat (4) tick();
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0; donetx = 1'b0;
    exp_q.push_back(8'h3C);
    check_eq("simul_count", count, 16);
    check_eq("simul_overflow", overflow, 0);
    check_eq("simul_full", full, 1);
    drain("burst");

    // Reset during SEND
    for (int i = 0; i < 6; i++) write_byte(8'h90 + 8'(i));
    n = 0;
    while (!newd && n < 50) begin tick(); n++; end
    repeat (3) tick();
    check_eq("midrst_in_send", newd, 1);
    #2 rst = 1'b0;
    #1;
    check_eq("midrst_newd", newd, 0);
    check_eq("midrst_count", count, 0);
    check_eq("midrst_dintx", dintx, 8'h00);
    check_eq("midrst_empty", empty, 1);
    got_q.delete();
    exp_q.delete();
    snap = newd_rises;
    tick();
    tick();
    rst = 1'b1;
    repeat (60) tick();
    check_eq("midrst_no_replay", newd_rises, snap);
    check_eq("midrst_still_empty", empty, 1);
    write_byte(8'hC3);
    exp_q.push_back(8'hC3);
    drain("post_reset");

    // Randomized traffic, occupancy kept below DEPTH
    for (int r = 0; r < 2; r++) begin
      auto_done = 1'b1;
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 8)) tick();
        b = 8'($urandom);
        write_byte(b);
        exp_q.push_back(b);
      end
      drain($sformatf("random%0d", r));
      check_eq($sformatf("random%0d_overflow", r), overflow, 0);
    end

`ifdef UART_TXF_TIMEOUT_EN
    write_byte(8'h55);
    write_byte(8'h66);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h66);
    wait_send_done("timeout");
    n = 0;
    while (!tx_timeout && n < 500) begin tick(); n++; end
    check_eq("timeout_cycles", n, TIMEOUT_CYC);
    tick();
    check_eq("timeout_one_pulse", tx_timeout, 0);
    drain("timeout");
`else
    write_byte(8'h55);
    exp_q.push_back(8'h55);
    wait_send_done("nowdog");
    snap = newd_rises;
    repeat (150) tick();
    check_eq("nowdog_tx_timeout", tx_timeout, 0);
    check_eq("nowdog_still_waiting", newd_rises, snap);
    pulse_done();
    drain("nowdog");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo_feeder.md
Name: uart_tx_fifo_feeder

Overview:
- Byte buffer plus handshake FSM upstream of the UART transmitter.
- Accepts bytes from the host side and stores them in a FIFO.
- Presents one byte at a time on dintx with a newd request, then waits for the transmitter's donetx before sending the next byte.
- Runs entirely on the system clk; donetx is synchronised into clk.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of two, 2..256.
- AW, 4, pointer width; AW = log2(DEPTH).
- NEWD_HOLD, 16, number of clk cycles newd is held high so the slower uclktx domain samples it; range 1..255.
- TIMEOUT_CYC, 65535, watchdog limit in clk cycles for the WAIT_DONE state. Used only with UART_TXF_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  host write strobe; one byte per cycle.
- wr_data  in  8  host byte.
- ovf_clr  in  1  clears the sticky overflow flag.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: a write was attempted while full.
- dintx  out  8  byte to the UART transmitter.
- newd  out  1  new-data request to the transmitter.
- donetx  in  1  transmitter done flag; asynchronous to clk.
- tx_timeout  out  1  one-cycle pulse on watchdog expiry (optional feature only).

Behaviour:
- Reset values (rst low, asynchronous):
  - Pointers and count = 0; empty = 1; full = 0; overflow = 0.
  - dintx = 8'h00; newd = 0; tx_timeout = 0.
  - FSM = IDLE; hold and watchdog counters = 0; donetx sync flops = 0.
- Reset release: reset deasserts asynchronously and takes effect on the next clk edge.
- Reset mid-transfer: the byte in flight is discarded; no replay.
- donetx synchronisation:
  - Two-flop synchroniser, then a third flop for edge detection.
  - done_rise = sync2 & ~sync3, so latency is 3 clk cycles from the donetx edge.
- FIFO write:
  - Accepted when wr_en=1 and (full=0 or a pop occurs in the same cycle).
  - When wr_en=1 and full=1 with no pop: data is dropped and overflow is set.
  - ovf_clr=1 clears overflow. If overflow is set in the same cycle as ovf_clr, set wins.
- FIFO pop: occurs only in the FSM LOAD state.
  - Simultaneous write and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- count, full and empty are registered and update in the cycle after the write/pop edge.
- FSM states:
  - IDLE: if empty=0, go to LOAD.
  - LOAD: dintx <= head entry, pop, go to SEND. dintx stays stable until the next LOAD.
  - SEND: newd=1; the hold counter counts NEWD_HOLD cycles, then newd=0 and go to WAIT_DONE.
  - WAIT_DONE: on done_rise go to IDLE. A done_rise seen in any other state is ignored.
- Throughput: minimum byte-to-byte spacing is 2 + NEWD_HOLD + transmitter frame time + 3 sync cycles.
- First byte timing: write into an empty FIFO, then empty falls 1 cycle later, then LOAD, then newd rises 2 cycles after empty falls.
- No combinational path from any input to any output.

Optional Feature:
- Macro: UART_TXF_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counts clk cycles while in WAIT_DONE.
  - On reaching TIMEOUT_CYC, the FSM goes to IDLE and tx_timeout pulses for one cycle; the byte is abandoned.
  - The counter clears on entry to WAIT_DONE.
- Without the macro:
  - No watchdog logic is present.
  - tx_timeout is tied to 0.
  - WAIT_DONE waits indefinitely.

Test Plan:
- Single byte: after reset, write 8'hA5.
  - dintx=8'hA5, newd high for exactly 16 cycles.
  - After a donetx pulse, the FSM returns to IDLE; empty=1, count=0.
- Burst order: write 8'h01..8'h10 back-to-back (16 bytes).
  - full=1 and count=16.
  - dintx presents 01..10 in order, one byte per donetx edge.
- Overflow: fill 16 entries, then write 8'hFF while full.
  - overflow=1 and count stays 16; 8'hFF is never transmitted.
  - ovf_clr clears overflow.
- Simultaneous: count=16 and a LOAD pop coincides with a write of 8'h3C.
  - count stays 16, overflow stays 0, and 8'h3C is transmitted last.
- Reset mid-transfer: pull rst low during SEND with 5 bytes queued.
  - newd=0, count=0, dintx=8'h00 immediately (asynchronously).
  - No newd is issued after release until a new write.
- Timeout (UART_TXF_TIMEOUT_EN, TIMEOUT_CYC=100): write 8'h55 and never pulse donetx.
  - tx_timeout pulses 100 cycles after WAIT_DONE is entered.
  - The next queued byte is then loaded.
